// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of a five-stage pipeline. Single-cycle ALU operations
//   load the EX/MEM register one edge after acceptance. MUL runs a
//   32-iteration shift-add multiply, holding the upstream stage via busy
//   until the low product word is written into EX/MEM.
//
//   Optional feature: define OVF_TRAP_EN to flag signed ADD/SUB overflow
//   on out_ovf and suppress the write-back (out_WB forced to 00) for that
//   entry. Without it out_ovf is always 0 and out_WB passes through.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              ID/EX entry valid
//   in_WB, in_M           write-back / memory controls
//   in_alu_op             decoded ALU operation
//   in_ALUSrc             1: operand B is in_imm, 0: in_rt_data
//   in_RegDst             1: destination rd, 0: rt
//   in_pc4                PC+4 of the instruction
//   in_rs_data            operand A
//   in_rt_data            operand B / store data
//   in_imm                sign-extended immediate
//   in_rt, in_rd          register specifiers
//   in_stall              downstream hold
//   in_flush              kill in-flight work
//   out_*                 EX/MEM register contents
//   busy                  upstream must hold ID/EX while high
module execute_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in_WB,
  input  logic [2:0]        in_M,
  input  logic [3:0]        in_alu_op,
  input  logic              in_ALUSrc,
  input  logic              in_RegDst,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_stall,
  input  logic              in_flush,
  output logic              out_valid,
  output logic [1:0]        out_WB,
  output logic [2:0]        out_M,
  output logic [DATA_W-1:0] out_branch_address,
  output logic              out_zero_flag,
  output logic [DATA_W-1:0] out_ALU_result,
  output logic [DATA_W-1:0] out_reg_write_data,
  output logic [4:0]        out_rd,
  output logic              out_ovf,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_mul, iter, ld_alu, ld_bubble, ld_mul, do_flush;

  function automatic logic signed [DATA_W-1:0] alu_fn(
    input logic [3:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = (a < b) ? DATA_W'(1) : '0;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef OVF_TRAP_EN
  function automatic logic ovf_fn(
    input logic [3:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] r
  );
    logic sa, sb, sr, v;
    sa = a[DATA_W-1];
    sb = b[DATA_W-1];
    sr = r[DATA_W-1];
    case (op)
      OP_ADD:  v = (sa == sb) && (sr != sa);
      OP_SUB:  v = (sa != sb) && (sr != sa);
      default: v = 1'b0;
    endcase
    return v;
  endfunction
`endif

  // ---- p0: operand select, single-cycle ALU, branch target ----
  logic signed [DATA_W-1:0] op_a_p0, op_b_p0, alu_res_p0;
  logic [DATA_W-1:0]        br_addr_p0;
  logic [4:0]               rd_p0;
  logic [1:0]               wb_p0;
  logic                     ovf_p0;

  assign op_a_p0    = in_rs_data;
  assign op_b_p0    = in_ALUSrc ? in_imm : in_rt_data;
  assign alu_res_p0 = alu_fn(in_alu_op, op_a_p0, op_b_p0);
  assign br_addr_p0 = in_pc4 + (in_imm << 2);
  assign rd_p0      = in_RegDst ? in_rd : in_rt;
`ifdef OVF_TRAP_EN
  assign ovf_p0     = ovf_fn(in_alu_op, op_a_p0, op_b_p0, alu_res_p0);
`else
  assign ovf_p0     = 1'b0;
`endif
  assign wb_p0      = ovf_p0 ? 2'b00 : in_WB;

  // ---- control FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (do_flush || start_mul)
        cnt <= '0;
      else if (iter && cnt != CNT_LAST)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    start_mul = 1'b0;
    iter      = 1'b0;
    ld_alu    = 1'b0;
    ld_bubble = 1'b0;
    ld_mul    = 1'b0;
    do_flush  = 1'b0;
    if (in_flush) begin
      do_flush  = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!in_stall) begin
            if (!in_valid) begin
              ld_bubble = 1'b1;
            end else if (in_alu_op == OP_MUL) begin
              start_mul = 1'b1;
              state_nxt = MUL;
            end else begin
              ld_alu = 1'b1;
            end
          end
        end
        MUL: begin
          iter = 1'b1;
          if (cnt == CNT_LAST)
            state_nxt = DONE;
        end
        DONE: begin
          if (!in_stall) begin
            ld_mul    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // ---- p1: shift-add multiply; low product word is sign-agnostic ----
  logic [DATA_W-1:0] mcand_p1, mplier_p1, acc_p1;
  logic [DATA_W-1:0] br_p1, rwd_p1;
  logic [4:0]        rd_p1;
  logic [1:0]        wb_p1;
  logic [2:0]        m_p1;

  always_ff @(posedge clk) begin
    if (start_mul) begin
      mcand_p1  <= op_a_p0;
      mplier_p1 <= op_b_p0;
      acc_p1    <= '0;
      br_p1     <= br_addr_p0;
      rwd_p1    <= in_rt_data;
      rd_p1     <= rd_p0;
      wb_p1     <= wb_p0;
      m_p1      <= in_M;
    end else if (iter) begin
      if (mplier_p1[0])
        acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  // ---- EX/MEM register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid          <= 1'b0;
      out_WB             <= '0;
      out_M              <= '0;
      out_branch_address <= '0;
      out_zero_flag      <= 1'b0;
      out_ALU_result     <= '0;
      out_reg_write_data <= '0;
      out_rd             <= '0;
      out_ovf            <= 1'b0;
    end else if (do_flush || ld_bubble) begin
      out_valid <= 1'b0;
      out_WB    <= '0;
      out_M     <= '0;
    end else if (ld_alu) begin
      out_valid          <= 1'b1;
      out_WB             <= wb_p0;
      out_M              <= in_M;
      out_branch_address <= br_addr_p0;
      out_zero_flag      <= (alu_res_p0 == '0);
      out_ALU_result     <= alu_res_p0;
      out_reg_write_data <= in_rt_data;
      out_rd             <= rd_p0;
      out_ovf            <= ovf_p0;
    end else if (ld_mul) begin
      out_valid          <= 1'b1;
      out_WB             <= wb_p1;
      out_M              <= m_p1;
      out_branch_address <= br_p1;
      out_zero_flag      <= (acc_p1 == '0);
      out_ALU_result     <= acc_p1;
      out_reg_write_data <= rwd_p1;
      out_rd             <= rd_p1;
      out_ovf            <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ALUSrc, in_RegDst, in_stall, in_flush;
  logic [1:0]  in_WB;
  logic [2:0]  in_M;
  logic [3:0]  in_alu_op;
  logic [31:0] in_pc4, in_rs_data, in_rt_data, in_imm;
  logic [4:0]  in_rt, in_rd;
  logic        out_valid, out_zero_flag, out_ovf, busy;
  logic [1:0]  out_WB;
  logic [2:0]  out_M;
  logic [31:0] out_branch_address, out_ALU_result, out_reg_write_data;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_WB(in_WB), .in_M(in_M),
    .in_alu_op(in_alu_op), .in_ALUSrc(in_ALUSrc), .in_RegDst(in_RegDst),
    .in_pc4(in_pc4), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_rt(in_rt), .in_rd(in_rd), .in_stall(in_stall),
    .in_flush(in_flush), .out_valid(out_valid), .out_WB(out_WB), .out_M(out_M),
    .out_branch_address(out_branch_address), .out_zero_flag(out_zero_flag),
    .out_ALU_result(out_ALU_result), .out_reg_write_data(out_reg_write_data),
    .out_rd(out_rd), .out_ovf(out_ovf), .busy(busy)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] res;
    logic        zero;
    logic [31:0] br;
    logic [31:0] rwd;
    logic [4:0]  rd;
    logic        ovf;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        alusrc;
    logic        regdst;
    logic [31:0] rs, rt, imm, pc4;
    logic [4:0]  rt_a, rd_a;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] x_res;
    logic        x_zero;
    logic [31:0] x_br;
    logic [4:0]  x_rd;
    logic [1:0]  x_wb;
    logic        x_ovf;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t vecs[12];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op, input logic alusrc,
                              input logic regdst, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic [31:0] pc4,
                              input logic [4:0] rt_a, input logic [4:0] rd_a,
                              input logic [1:0] wb, input logic [2:0] m,
                              input logic [31:0] x_res, input logic x_zero,
                              input logic [31:0] x_br, input logic [4:0] x_rd,
                              input logic [1:0] x_wb, input logic x_ovf);
    vec_t v;
    v.name = nm; v.op = op; v.alusrc = alusrc; v.regdst = regdst;
    v.rs = rs; v.rt = rt; v.imm = imm; v.pc4 = pc4; v.rt_a = rt_a; v.rd_a = rd_a;
    v.wb = wb; v.m = m; v.x_res = x_res; v.x_zero = x_zero; v.x_br = x_br;
    v.x_rd = x_rd; v.x_wb = x_wb; v.x_ovf = x_ovf;
    return v;
  endfunction

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e.name = v.name; e.valid = 1'b1; e.wb = v.x_wb; e.m = v.m; e.res = v.x_res;
    e.zero = v.x_zero; e.br = v.x_br; e.rwd = v.rt; e.rd = v.x_rd; e.ovf = v.x_ovf;
    return e;
  endfunction

  function automatic exp_t bubble_exp(input string nm);
    exp_t e;
    e.name = nm; e.valid = 1'b0; e.wb = 2'b00; e.m = 3'b000; e.res = '0;
    e.zero = 1'b0; e.br = '0; e.rwd = '0; e.rd = '0; e.ovf = 1'b0;
    return e;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1; in_alu_op = v.op; in_ALUSrc = v.alusrc; in_RegDst = v.regdst;
    in_rs_data = v.rs; in_rt_data = v.rt; in_imm = v.imm; in_pc4 = v.pc4;
    in_rt = v.rt_a; in_rd = v.rd_a; in_WB = v.wb; in_M = v.m;
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".valid"}, 32'(out_valid), 32'(e.valid));
      chk({e.name, ".WB"}, 32'(out_WB), 32'(e.wb));
      chk({e.name, ".M"}, 32'(out_M), 32'(e.m));
      if (e.valid) begin
        chk({e.name, ".ALU_result"}, out_ALU_result, e.res);
        chk({e.name, ".zero"}, 32'(out_zero_flag), 32'(e.zero));
        chk({e.name, ".branch"}, out_branch_address, e.br);
        chk({e.name, ".rwd"}, out_reg_write_data, e.rwd);
        chk({e.name, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({e.name, ".ovf"}, 32'(out_ovf), 32'(e.ovf));
      end
      last_exp = e;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    drive_vec(v);
    sb.push_back(vec_exp(v));
    @(posedge clk); #1;
    compare_pop();
  endtask

  // Multiply: bench computes the low product word directly; hold>0 keeps
  // in_stall high so the result waits in DONE until edge 40 is passed.
  task automatic mul_seq(input string nm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic alusrc, input int hold);
    exp_t        e;
    int          n;
    logic [31:0] b;
    logic [31:0] prod;
    b = alusrc ? imm : rt;
    prod = rs * b;
    e.name = nm; e.valid = 1'b1; e.wb = 2'b01; e.m = 3'b001; e.res = prod;
    e.zero = (prod == 32'd0); e.br = 32'h200 + (imm << 2); e.rwd = rt;
    e.rd = 5'd17; e.ovf = 1'b0;
    in_valid = 1'b1; in_alu_op = OP_MUL; in_ALUSrc = alusrc; in_RegDst = 1'b1;
    in_rs_data = rs; in_rt_data = rt; in_imm = imm; in_pc4 = 32'h200;
    in_rt = 5'd2; in_rd = 5'd17; in_WB = 2'b01; in_M = 3'b001;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold > 0) in_stall = 1'b1;
    chk({nm, ".busy_after_accept"}, 32'(busy), 32'd1);
    n = 1;
    while (busy && n < 120) begin
      if (hold > 0 && n == 40) begin
        chk({nm, ".busy_done_stall"}, 32'(busy), 32'd1);
        chk({nm, ".held_result"}, out_ALU_result, last_exp.res);
        chk({nm, ".held_valid"}, 32'(out_valid), 32'(last_exp.valid));
        in_stall = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".latency_edges"}, 32'(n), (hold > 0) ? 32'd41 : 32'd34);
    compare_pop();
  endtask

  task automatic abort_seq(input bit use_reset);
    in_valid = 1'b1; in_alu_op = OP_MUL; in_ALUSrc = 1'b0; in_RegDst = 1'b1;
    in_rs_data = 32'd3; in_rt_data = 32'd5; in_imm = 32'd0; in_pc4 = 32'h300;
    in_rt = 5'd1; in_rd = 5'd2; in_WB = 2'b11; in_M = 3'b111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      chk("reset_abort.busy", 32'(busy), 32'd0);
      chk("reset_abort.valid", 32'(out_valid), 32'd0);
      chk("reset_abort.ALU_result", out_ALU_result, 32'd0);
      chk("reset_abort.rd", 32'(out_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_release.valid", 32'(out_valid), 32'd0);
    end else begin
      in_flush = 1'b1;
      in_stall = 1'b1;
      drive_vec(vecs[0]);
      sb.push_back(bubble_exp("flush_mul"));
      @(posedge clk); #1;
      compare_pop();
      chk("flush_mul.busy", 32'(busy), 32'd0);
      in_stall = 1'b0;
      sb.push_back(bubble_exp("flush_over_valid"));
      @(posedge clk); #1;
      compare_pop();
      chk("flush_over_valid.busy", 32'(busy), 32'd0);
      in_flush = 1'b0;
    end
    apply_vec(vecs[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_ALUSrc = 1'b0; in_RegDst = 1'b0; in_stall = 1'b0; in_flush = 1'b0;
    in_WB = '0; in_M = '0; in_alu_op = '0; in_pc4 = '0; in_rs_data = '0;
    in_rt_data = '0; in_imm = '0; in_rt = '0; in_rd = '0;

    vecs[0]  = mk("add",      OP_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 32'd1, 32'h100, 5'd3, 5'd9,
                  2'b01, 3'b000, 32'd12, 1'b0, 32'h104, 5'd9, 2'b01, 1'b0);
    vecs[1]  = mk("sub_zero", OP_SUB, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd3, 32'h40, 5'd4, 5'd20,
                  2'b11, 3'b001, 32'd0, 1'b1, 32'h4C, 5'd4, 2'b11, 1'b0);
    vecs[2]  = mk("and",      OP_AND, 1'b0, 1'b1, 32'hF0F0FF00, 32'h0FF00F0F, 32'd0, 32'd0, 5'd1, 5'd5,
                  2'b01, 3'b010, 32'h00F00F00, 1'b0, 32'd0, 5'd5, 2'b01, 1'b0);
    vecs[3]  = mk("or_imm",   OP_OR,  1'b1, 1'b1, 32'hF0000000, 32'hFFFFFFFF, 32'h11, 32'h1000, 5'd2, 5'd6,
                  2'b10, 3'b100, 32'hF0000011, 1'b0, 32'h1044, 5'd6, 2'b10, 1'b0);
    vecs[4]  = mk("slt_neg",  OP_SLT, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd7,
                  2'b01, 3'b000, 32'd1, 1'b0, 32'd0, 5'd7, 2'b01, 1'b0);
    vecs[5]  = mk("slt_pos",  OP_SLT, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd8, 5'd0,
                  2'b01, 3'b000, 32'd0, 1'b1, 32'd0, 5'd8, 2'b01, 1'b0);
    vecs[6]  = mk("nor",      OP_NOR, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'h20, 5'd0, 5'd31,
                  2'b01, 3'b000, 32'hFFFFFFFF, 1'b0, 32'h20, 5'd31, 2'b01, 1'b0);
    vecs[7]  = mk("add_wrap", OP_ADD, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd0, 5'd10,
                  2'b01, 3'b000, 32'd1, 1'b0, 32'd0, 5'd10, 2'b01, 1'b0);
    vecs[8]  = mk("add_ovf",  OP_ADD, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd11,
                  2'b10, 3'b000, 32'h80000000, 1'b0, 32'd0, 5'd11, TRAP ? 2'b00 : 2'b10, TRAP);
    vecs[9]  = mk("sub_ovf",  OP_SUB, 1'b0, 1'b1, 32'h80000000, 32'd1, 32'd0, 32'd0, 5'd0, 5'd12,
                  2'b01, 3'b000, 32'h7FFFFFFF, 1'b0, 32'd0, 5'd12, TRAP ? 2'b00 : 2'b01, TRAP);
    vecs[10] = mk("bad_op",   4'b0011, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 5'd0, 5'd13,
                  2'b01, 3'b000, 32'd0, 1'b1, 32'd0, 5'd13, 2'b01, 1'b0);
    vecs[11] = mk("br_neg",   OP_ADD, 1'b0, 1'b1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h100, 5'd0, 5'd14,
                  2'b01, 3'b000, 32'd0, 1'b1, 32'hFC, 5'd14, 2'b01, 1'b0);

    // Reset state and clean release
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ALU_result", out_ALU_result, 32'd0);
    chk("reset.branch", out_branch_address, 32'd0);
    chk("reset.WB", 32'(out_WB), 32'd0);
    chk("reset.ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release.valid", 32'(out_valid), 32'd0);

    // Single-cycle table
    for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

    // Stall holds EX/MEM after an AND, then the waiting ADD is accepted
    apply_vec(vecs[2]);
    in_stall = 1'b1;
    drive_vec(vecs[0]);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(last_exp);
      @(posedge clk); #1;
      compare_pop();
      chk("stall.busy", 32'(busy), 32'd0);
    end
    in_stall = 1'b0;
    apply_vec(vecs[0]);

    // Bubble clears valid and controls
    in_valid = 1'b0;
    sb.push_back(bubble_exp("bubble"));
    @(posedge clk); #1;
    compare_pop();

    // Multi-cycle multiply
    mul_seq("mul_neg", 32'd3, 32'hFFFFFFFC, 32'd0, 1'b0, 0);
    mul_seq("mul_big_stall", 32'h12345678, 32'h9ABCDEF0, 32'd4, 1'b0, 1);
    mul_seq("mul_imm", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFB, 1'b1, 0);
    mul_seq("mul_zero", 32'd0, 32'd5, 32'd0, 1'b0, 0);

    // Abort by flush, then by reset
    abort_seq(1'b0);
    abort_seq(1'b1);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
